// File: rtl/n64_pkg.sv
// rtl/n64_pkg.sv - shared constants, button layout and FSM encoding for the N64 reply receiver
package n64_pkg;

    // Reply payload length; the stop bit follows the last data bit
    localparam int N64_DATA_BITS = 32;

    // Button bit positions inside the 32-bit reply word (bit31 arrives first)
    localparam int BTN_A       = 31;
    localparam int BTN_B       = 30;
    localparam int BTN_Z       = 29;
    localparam int BTN_START   = 28;
    localparam int BTN_D_UP    = 27;
    localparam int BTN_D_DOWN  = 26;
    localparam int BTN_D_LEFT  = 25;
    localparam int BTN_D_RIGHT = 24;
    localparam int BTN_RSVD_HI = 23;
    localparam int BTN_RSVD_LO = 22;
    localparam int BTN_L       = 21;
    localparam int BTN_R       = 20;
    localparam int BTN_C_UP    = 19;
    localparam int BTN_C_DOWN  = 18;
    localparam int BTN_C_LEFT  = 17;
    localparam int BTN_C_RIGHT = 16;
    localparam int STICK_X_MSB = 15;
    localparam int STICK_X_LSB = 8;
    localparam int STICK_Y_MSB = 7;
    localparam int STICK_Y_LSB = 0;

    // Structured view of the reply word for consumers of the buttons output
    typedef struct packed {
        logic       a;
        logic       b;
        logic       z;
        logic       start;
        logic       d_up;
        logic       d_down;
        logic       d_left;
        logic       d_right;
        logic [1:0] rsvd;
        logic       l;
        logic       r;
        logic       c_up;
        logic       c_down;
        logic       c_left;
        logic       c_right;
        logic [7:0] stick_x;
        logic [7:0] stick_y;
    } n64_buttons_t;

    // Receiver FSM encoding
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_FALL = 3'd1,
        ST_LOW       = 3'd2,
        ST_DONE      = 3'd3,
        ST_ERR       = 3'd4
    } rx_state_t;

    // Majority of three samples, used by the optional glitch filter
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/n64_edge_sync.sv
// rtl/n64_edge_sync.sv - din synchronizer with optional majority filter (N64_RX_GLITCH_FILTER_EN) and edge pulses
module n64_edge_sync
    import n64_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic fall,
    output logic rise
);

    logic sync_1;
    logic sync_2;
    logic line_level;
    logic prev_level;

    // Two-flop synchronizer; the line idles high so reset to 1 to avoid a false fall
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_1 <= 1'b1;
            sync_2 <= 1'b1;
        end else begin
            sync_1 <= din;
            sync_2 <= sync_1;
        end
    end

`ifdef N64_RX_GLITCH_FILTER_EN
    logic tap_1;
    logic tap_2;

    // Two history taps; majority over three consecutive samples drops 1-cycle pulses
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tap_1 <= 1'b1;
            tap_2 <= 1'b1;
        end else begin
            tap_1 <= sync_2;
            tap_2 <= tap_1;
        end
    end

    assign line_level = maj3(sync_2, tap_1, tap_2);
`else
    assign line_level = sync_2;
`endif

    // Previous level for edge detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_level <= 1'b1;
        end else begin
            prev_level <= line_level;
        end
    end

    assign level = line_level;
    assign fall  = prev_level & ~line_level;
    assign rise  = ~prev_level & line_level;

endmodule

// File: rtl/n64_buttons_rx.sv
// rtl/n64_buttons_rx.sv - N64 controller reply decoder (pulse-width bits to 32-bit word); N64_RX_GLITCH_FILTER_EN adds input filter
module n64_buttons_rx
    import n64_pkg::*;
#(
    parameter int CLK_PER_US = 4,
    parameter int TIMEOUT_US = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        din,
    input  logic        arm,
    output logic [31:0] buttons,
    output logic        valid,
    output logic        busy,
    output logic        timeout_err
);

    localparam int LIMIT = TIMEOUT_US * CLK_PER_US;
    localparam int CW    = $clog2(LIMIT + 1);

    // Last idle cycle before abort, stuck-low ceiling, and the 1/0 width threshold
    localparam logic [CW-1:0] TMO_LAST  = CW'(LIMIT - 1);
    localparam logic [CW-1:0] CNT_MAX   = CW'(LIMIT);
    localparam logic [CW-1:0] ONE_LIMIT = CW'(2 * CLK_PER_US);
    localparam logic [5:0]    STOP_IDX  = 6'(N64_DATA_BITS);
    localparam logic [5:0]    BIT_MAX   = 6'h3f;

    logic            line_level;
    logic            line_fall;
    logic            line_rise;

    rx_state_t       state;
    logic [CW-1:0]   tmo_cnt;
    logic [CW-1:0]   low_cnt;
    logic [5:0]      bit_cnt;
    logic [31:0]     shreg;
    logic            bit_val;

    n64_edge_sync u_edge_sync (
        .clk   (clk),
        .reset (reset),
        .din   (din),
        .level (line_level),
        .fall  (line_fall),
        .rise  (line_rise)
    );

    // Short low pulse is a '1', long low pulse is a '0'
    assign bit_val = (low_cnt < ONE_LIMIT);

    // Reply FSM: counters, shift register and registered strobes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            tmo_cnt     <= '0;
            low_cnt     <= '0;
            bit_cnt     <= '0;
            shreg       <= '0;
            buttons     <= '0;
            valid       <= 1'b0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            valid       <= 1'b0;
            timeout_err <= 1'b0;

            if (arm) begin
                // Any arm (idle, mid-reply, or on the strobe cycle) starts a fresh reply
                state   <= ST_WAIT_FALL;
                tmo_cnt <= '0;
                low_cnt <= '0;
                bit_cnt <= '0;
                shreg   <= '0;
                busy    <= 1'b1;
            end else begin
                case (state)
                    ST_IDLE: begin
                        busy <= 1'b0;
                    end

                    ST_WAIT_FALL: begin
                        if (line_fall) begin
                            state   <= ST_LOW;
                            low_cnt <= CW'(1);
                        end else if (tmo_cnt == TMO_LAST) begin
                            state       <= ST_ERR;
                            timeout_err <= 1'b1;
                            busy        <= 1'b0;
                        end else if (tmo_cnt != CNT_MAX) begin
                            tmo_cnt <= tmo_cnt + CW'(1);
                        end
                    end

                    ST_LOW: begin
                        if (line_rise) begin
                            if (bit_cnt == STOP_IDX) begin
                                // Stop bit: width is irrelevant, publish the word
                                state   <= ST_DONE;
                                buttons <= shreg;
                                valid   <= 1'b1;
                                busy    <= 1'b0;
                            end else begin
                                state   <= ST_WAIT_FALL;
                                shreg   <= {shreg[30:0], bit_val};
                                tmo_cnt <= '0;
                                if (bit_cnt != BIT_MAX) begin
                                    bit_cnt <= bit_cnt + 6'd1;
                                end
                            end
                        end else if (low_cnt == CNT_MAX && !line_level) begin
                            // Line held low too long: controller or wiring fault
                            state       <= ST_ERR;
                            timeout_err <= 1'b1;
                            busy        <= 1'b0;
                        end else if (low_cnt != CNT_MAX) begin
                            low_cnt <= low_cnt + CW'(1);
                        end
                    end

                    ST_DONE: begin
                        state <= ST_IDLE;
                    end

                    ST_ERR: begin
                        state <= ST_IDLE;
                    end

                    default: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
